serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. It sequences a single `full_gate` cell over two WIDTH-bit operands, one bit per clock, LSB first. The carry is held in a flop between bits. It presents a start/busy/done handshake to the requester and holds the registered sum and carry-out until the next result. It lets the datapath add arbitrary-width operands at the cost of one adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH ≥ 2.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new addition. Sampled only in IDLE or DONE.
- `opA`, input, WIDTH: operand A. Captured on the accepting edge.
- `opB`, input, WIDTH: operand B. Captured on the accepting edge.
- `cin`, input, 1: carry-in. Captured on the accepting edge.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse, high while in DONE.
- `sum`, output, WIDTH: registered result, opA+opB+cin mod 2^WIDTH.
- `cout`, output, 1: registered carry-out of the addition.

## Operation
- Internal storage:
  - shift registers `a_sr`, `b_sr` (WIDTH each), working sum shift register `s_sr` (WIDTH), carry flop `c_q`;
  - bit counter `cnt`, $clog2(WIDTH+1) bits;
  - result registers `sum` and `cout`.
- One `full_gate` instance is driven by inA=a_sr[0], inB=b_sr[0], Cin=c_q. Its outputs are outS2 (sum bit) and Cout0 (carry out).
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: load a_sr←opA, b_sr←opB, c_q←cin, cnt←0, then go to RUN. With start=0, stay in IDLE.
- RUN, every cycle:
  - a_sr and b_sr shift right by one, zero-fill;
  - s_sr←{outS2, s_sr[WIDTH-1:1]};
  - c_q←Cout0;
  - cnt←cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1 (the last bit), load sum←{outS2, s_sr[WIDTH-1:1]} and cout←Cout0, then go to DONE.
- start is ignored in RUN. No queueing, no error flag. The operands in flight are unaffected.
- DONE:
  - start=1 behaves exactly like start in IDLE (load, go to RUN). This allows back-to-back operation.
  - start=0 goes to IDLE.
- sum and cout change only on the RUN→DONE edge. They hold their value through IDLE, DONE and the whole of the next RUN.
- opA, opB and cin may change freely after the accepting edge.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, and all internal registers cleared. This holds regardless of state. Reset mid-RUN abandons the operation, and no done pulse follows.
- Reset release: the first edge with rst_n=1 may accept start.
- Let E0 be the edge that accepts start:
  - busy is high for the WIDTH cycles after edges E0..E(WIDTH-1);
  - bits 0..WIDTH-1 are consumed on edges E1..EWIDTH;
  - done is high for exactly one cycle, after edge EWIDTH;
  - sum and cout are valid from the same cycle that done is high.
- Latency from the accepting edge to done high is WIDTH cycles.
- Maximum throughput is one addition per WIDTH+1 cycles, with start held or re-asserted during DONE.
- busy and done are never high simultaneously. Both are registered-state decodes, with no combinational path from start.

## Test plan
- WIDTH=8: reset, then opA=0x5A, opB=0x33, cin=0, start pulse. Required: busy for 8 cycles, then done for 1 cycle, with sum=0x8D and cout=0.
- 0xFF+0x01, cin=0 → sum=0x00, cout=1. Then 0xFF+0xFF, cin=1 → sum=0xFF, cout=1. Then 0x00+0x00, cin=1 → sum=0x01, cout=0.
- Start 0x10+0x20. Re-assert start with 0xAA+0x55 during cycles 3 and 5 of busy. Required: done once with sum=0x30, and no second operation starts.
- Start held high continuously with a fresh operand each accept. Required: done pulses every 9 cycles, and each result matches its own operands.
- Drop rst_n in cycle 4 of RUN. Required: outputs go to 0 immediately (asynchronously), and no done pulse follows. After release, 0x7F+0x01 → sum=0x80, cout=0.
- 200 random operand/cin pairs with WIDTH=8, then WIDTH=2 and WIDTH=16. Compare {cout,sum} against opA+opB+cin and check done timing against the E0+WIDTH rule.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_gate cell walks two WIDTH-bit operands
// LSB first, holding the carry in a flop, behind a start/busy/done handshake.

module full_gate (
  input  logic inA,
  input  logic inB,
  input  logic Cin,
  output logic outS2,
  output logic Cout0
);
  assign outS2 = inA ^ inB ^ Cin;
  assign Cout0 = (inA & inB) | (Cin & (inA ^ inB));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s, fa_c;

  full_gate u_fa (
    .inA   (a_sr_q[0]),
    .inB   (b_sr_q[0]),
    .Cin   (c_q),
    .outS2 (fa_s),
    .Cout0 (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start exactly like IDLE so additions can run back to back
        if (start) begin
          a_sr_d  = opA;
          b_sr_d  = opB;
          c_d     = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
        c_d    = fa_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 2, 8 and 16; expected results are queued
// when an operation is launched and popped when its done pulse appears.

module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] opA, opB;
  logic        cin;
  int          sel_w;

  logic        st2, st8, st16;
  logic        busy2, done2, cout2;
  logic        busy8, done8, cout8;
  logic        busy16, done16, cout16;
  logic [1:0]  sum2;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  logic        busy_s, done_s;
  logic [16:0] res_s;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign st2  = start && (sel_w == 2);
  assign st8  = start && (sel_w == 8);
  assign st16 = start && (sel_w == 16);

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .opA(opA[1:0]), .opB(opB[1:0]),
    .cin(cin), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .opA(opA[7:0]), .opB(opB[7:0]),
    .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .opA(opA), .opB(opB),
    .cin(cin), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  always_comb begin
    busy_s = busy8;
    done_s = done8;
    res_s  = {8'b0, cout8, sum8};
    case (sel_w)
      2: begin
        busy_s = busy2;
        done_s = done2;
        res_s  = {14'b0, cout2, sum2};
      end
      16: begin
        busy_s = busy16;
        done_s = done16;
        res_s  = {cout16, sum16};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model(input int w, input int a, input int b, input int ci);
    int m;
    m = (1 << w) - 1;
    return ((a & m) + (b & m) + ci) & ((1 << (w + 1)) - 1);
  endfunction

  task automatic pop_chk(input string tag);
    int e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: got empty scoreboard expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(res_s), e);
    end
  endtask

  // launch one addition and check busy window, done timing and result
  task automatic do_op(input int w, input int a, input int b, input int ci, input string tag);
    int bad;
    sel_w = w;
    @(negedge clk);
    opA = a[15:0]; opB = b[15:0]; cin = ci[0]; start = 1'b1;
    exp_q.push_back(model(w, a, b, ci));
    @(negedge clk);
    start = 1'b0;
    opA = 16'($urandom); opB = 16'($urandom); cin = 1'($urandom);
    bad = 0;
    for (int k = 1; k <= w; k++) begin
      if (k > 1) @(negedge clk);
      if (!(busy_s === 1'b1 && done_s === 1'b0)) bad++;
    end
    chk({tag, "_busy"}, bad, 0);
    @(negedge clk);
    chk({tag, "_done"}, {busy_s, done_s}, 2'b01);
    pop_chk({tag, "_res"});
  endtask

  initial begin
    int bad;
    sel_w = 8; rst_n = 1'b0; start = 1'b0; opA = '0; opB = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl8", {busy8, done8, cout8}, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_all16", {busy16, done16, cout16, sum16}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8, 'h5A, 'h33, 0, "basic");
    do_op(8, 'hFF, 'h01, 0, "ff_01");
    do_op(8, 'hFF, 'hFF, 1, "ff_ff_c");
    do_op(8, 'h00, 'h00, 1, "zero_c");

    // start re-asserted mid-run must be ignored
    sel_w = 8;
    @(negedge clk);
    opA = 16'h10; opB = 16'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8, 'h10, 'h20, 0));
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!(busy_s === 1'b1 && done_s === 1'b0)) bad++;
      start = (k == 3 || k == 5);
      opA = 16'hAA; opB = 16'h55;
    end
    chk("ign_busy", bad, 0);
    @(negedge clk);
    chk("ign_done", {busy_s, done_s}, 2'b01);
    pop_chk("ign_res");
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_s !== 1'b0 || done_s !== 1'b0) bad++;
    end
    chk("ign_no_second", bad, 0);

    // start held high: one result every WIDTH+1 cycles
    @(negedge clk);
    opA = 16'h3C; opB = 16'h4B; cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(8, 'h3C, 'h4B, 1));
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (!(busy_s === 1'b1 && done_s === 1'b0)) bad++;
      end
      @(negedge clk);
      chk("held_done", {busy_s, done_s}, 2'b01);
      pop_chk("held_res");
      if (n < 5) begin
        opA = 16'($urandom); opB = 16'($urandom); cin = 1'($urandom);
        exp_q.push_back(model(8, int'(opA), int'(opB), int'(cin)));
      end else begin
        start = 1'b0;
      end
    end
    chk("held_busy", bad, 0);
    do_op(8, 'hC3, 'h11, 0, "pre_rst");

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    opA = 16'h12; opB = 16'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {busy8, done8, cout8}, 0);
    chk("arst_sum", sum8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_s !== 1'b0 || done_s !== 1'b0) bad++;
    end
    chk("arst_no_done", bad, 0);
    do_op(8, 'h7F, 'h01, 0, "post_rst");

    for (int i = 0; i < 200; i++)
      do_op(8, int'($urandom), int'($urandom), int'($urandom_range(0, 1)), "rnd8");
    for (int i = 0; i < 200; i++)
      do_op(2, int'($urandom), int'($urandom), int'($urandom_range(0, 1)), "rnd2");
    do_op(16, 'hFFFF, 'h0000, 1, "w16_wrap");
    for (int i = 0; i < 200; i++)
      do_op(16, int'($urandom), int'($urandom), int'($urandom_range(0, 1)), "rnd16");

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
